// File: rtl/mac_tx_framegen_if.sv
// rtl/mac_tx_framegen_if.sv - FIFO write port and XGMII-style output bundle for mac_tx_framegen
interface mac_tx_framegen_if #(
    parameter int N_CHANNELS = 4,
    parameter int W_BYTE     = 8
);
    logic                         i_buf_wen;
    logic [N_CHANNELS-1:0]        i_buf_wctrl;
    logic [N_CHANNELS*W_BYTE-1:0] i_buf_wdata;
    logic [N_CHANNELS*W_BYTE-1:0] o_txd;
    logic [N_CHANNELS-1:0]        o_txc;
    logic                         o_tx_valid;

    modport master (output i_buf_wen, i_buf_wctrl, i_buf_wdata,
                    input  o_txd, o_txc, o_tx_valid);
    modport slave  (input  i_buf_wen, i_buf_wctrl, i_buf_wdata,
                    output o_txd, o_txc, o_tx_valid);
endinterface

// File: rtl/mac_tx_framegen.sv
// rtl/mac_tx_framegen.sv - TX word generator: lane FIFO, header/idle/error word mux, frame FSM
module mac_tx_framegen #(
    parameter int N_CHANNELS = 4,
    parameter int W_BYTE     = 8,
    parameter int BUF_DEPTH  = 8,
    parameter int W_HDR_ID   = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clk_en,
    input  logic                i_buf_clear,
    mac_tx_framegen_if.slave    buf_if,
    input  logic                i_buf_ren,
    output logic                o_buf_empty,
    input  logic [W_HDR_ID-1:0] i_hdr_id,
    input  logic                i_gen_hdr,
    input  logic                i_gen_data,
    input  logic                i_gen_idle,
    input  logic                i_gen_ifg,
    input  logic                i_gen_error,
    output logic                o_in_frame,
    output logic [15:0]         o_frame_cnt,
    output logic                o_overflow,
    output logic                o_underflow,
    output logic                o_proto_err
);
    localparam int W_PTR   = $clog2(BUF_DEPTH);
    localparam int W_CNT   = W_PTR + 1;
    localparam int W_DATA  = N_CHANNELS * W_BYTE;
    localparam int W_ENTRY = N_CHANNELS + W_DATA;

    function automatic logic [W_DATA-1:0] lanes(input logic [7:0] first, input logic [7:0] mid,
                                                input logic [7:0] last);
        logic [W_DATA-1:0] w;
        for (int i = 0; i < N_CHANNELS; i++) w[i*W_BYTE +: W_BYTE] = W_BYTE'(mid);
        w[(N_CHANNELS-1)*W_BYTE +: W_BYTE] = W_BYTE'(last);
        w[0 +: W_BYTE] = W_BYTE'(first);
        return w;
    endfunction

    localparam logic [W_DATA-1:0] IDLE_WORD = lanes(8'h07, 8'h07, 8'h07);
    localparam logic [W_DATA-1:0] ERR_WORD  = lanes(8'hFE, 8'hFE, 8'hFE);
    localparam logic [W_DATA-1:0] HDR0_WORD = lanes(8'hFB, 8'h55, 8'h55);
    localparam logic [W_DATA-1:0] HDR1_WORD = lanes(8'h55, 8'h55, 8'hD5);

    typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

    logic [W_ENTRY-1:0]    mem_q [BUF_DEPTH];
    logic [W_PTR-1:0]      wr_ptr_q, rd_ptr_q;
    logic [W_CNT-1:0]      count_q;
    state_t                state_q, state_d;
    logic [W_DATA-1:0]     txd_q, txd_d;
    logic [N_CHANNELS-1:0] txc_q, txc_d;
    logic                  tx_valid_q;
    logic [15:0]           frame_cnt_q;
    logic                  overflow_q, underflow_q, proto_err_q;

    logic                  full, do_pop, do_write, set_overflow;
    logic                  set_underflow, set_proto_err, frame_done, head_has_term;
    logic [W_DATA-1:0]     head_data;
    logic [N_CHANNELS-1:0] head_ctrl;

    assign {head_ctrl, head_data} = mem_q[rd_ptr_q];
    assign o_buf_empty  = (count_q == '0);
    assign full         = (count_q == W_CNT'(BUF_DEPTH));
    // Clear wins over any same-cycle FIFO traffic; a read frees the slot a full write needs.
    assign do_pop       = i_clk_en && !i_buf_clear && i_buf_ren && !o_buf_empty;
    assign do_write     = i_clk_en && !i_buf_clear && buf_if.i_buf_wen && (!full || do_pop);
    assign set_overflow = i_clk_en && !i_buf_clear && buf_if.i_buf_wen && full && !do_pop;

    always_comb begin
        head_has_term = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (head_ctrl[i] && head_data[i*W_BYTE +: W_BYTE] == W_BYTE'(8'hFD)) head_has_term = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        txd_d         = IDLE_WORD;
        txc_d         = '1;
        set_underflow = 1'b0;
        set_proto_err = 1'b0;
        frame_done    = 1'b0;
        if (i_gen_error) begin
            txd_d   = ERR_WORD;
            state_d = ST_IDLE;
        end else if (i_gen_hdr) begin
            if (i_hdr_id != '0) begin
                txd_d = HDR1_WORD;
                txc_d = '0;
            end else if (state_q == ST_IN_FRAME) begin
                txd_d         = ERR_WORD;
                set_proto_err = 1'b1;
                state_d       = ST_IDLE;
            end else begin
                txd_d   = HDR0_WORD;
                txc_d   = N_CHANNELS'(1);
                state_d = ST_IN_FRAME;
            end
        end else if (i_gen_data) begin
            if (o_buf_empty) begin
                txd_d         = ERR_WORD;
                set_underflow = 1'b1;
                state_d       = ST_IDLE;
            end else begin
                txd_d = head_data;
                txc_d = head_ctrl;
                if (state_q == ST_IN_FRAME && head_has_term) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
        end else if (i_gen_ifg || i_gen_idle) begin
            txd_d = IDLE_WORD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            txd_q       <= IDLE_WORD;
            txc_q       <= '1;
            tx_valid_q  <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (i_clk_en) begin
            tx_valid_q <= 1'b1;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            state_q    <= state_d;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (i_buf_clear) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
                proto_err_q <= 1'b0;
            end else begin
                if (do_write) begin
                    mem_q[wr_ptr_q] <= {buf_if.i_buf_wctrl, buf_if.i_buf_wdata};
                    wr_ptr_q        <= wr_ptr_q + W_PTR'(1);
                end
                if (do_pop) rd_ptr_q <= rd_ptr_q + W_PTR'(1);
                if (do_write && !do_pop) count_q <= count_q + W_CNT'(1);
                else if (do_pop && !do_write) count_q <= count_q - W_CNT'(1);
                if (set_overflow)  overflow_q  <= 1'b1;
                if (set_underflow) underflow_q <= 1'b1;
                if (set_proto_err) proto_err_q <= 1'b1;
            end
        end else begin
            tx_valid_q <= 1'b0;
        end
    end

    assign buf_if.o_txd      = txd_q;
    assign buf_if.o_txc      = txc_q;
    assign buf_if.o_tx_valid = tx_valid_q;
    assign o_in_frame        = (state_q == ST_IN_FRAME);
    assign o_frame_cnt       = frame_cnt_q;
    assign o_overflow        = overflow_q;
    assign o_underflow       = underflow_q;
    assign o_proto_err       = proto_err_q;
endmodule

// File: doc/mac_tx_framegen.md
MAC_TX_FRAMEGEN -- requirements
Module: mac_tx_framegen

Interface
REQ-001 Parameter N_CHANNELS, 4, number of byte lanes per transfer; lane 0 occupies bits [7:0] and is transmitted first.
REQ-002 Parameter W_BYTE, 8, width of one lane in bits.
REQ-003 Parameter BUF_DEPTH, 8, number of FIFO entries; SHALL be a power of two and at least 4.
REQ-004 Parameter W_HDR_ID, 1, width of i_hdr_id.
REQ-005 Port list (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_reset, in, 1, reset; synchronous, active-high.
- i_clk_en, in, 1, clock enable shared with the TX controller.
- i_buf_clear, in, 1, flush the FIFO.
- i_buf_wen, in, 1, write one entry.
- i_buf_wctrl, in, N_CHANNELS, per-lane control flag of the write entry.
- i_buf_wdata, in, N_CHANNELS*W_BYTE, write data.
- i_buf_ren, in, 1, consume the FIFO head this cycle.
- o_buf_empty, out, 1, FIFO holds no entries.
- i_hdr_id, in, W_HDR_ID, header word select.
- i_gen_hdr, i_gen_data, i_gen_idle, i_gen_ifg, i_gen_error, in, 1 each, output word source selects.
- o_txd, out, N_CHANNELS*W_BYTE, XGMII-style data.
- o_txc, out, N_CHANNELS, XGMII-style control flags.
- o_tx_valid, out, 1, o_txd/o_txc were updated this cycle.
- o_in_frame, out, 1, frame in progress.
- o_frame_cnt, out, 16, count of completed frames.
- o_overflow, o_underflow, o_proto_err, out, 1 each, sticky error flags.

Function
REQ-006 All state SHALL advance only on cycles where i_clk_en=1; when i_clk_en=0, every register holds and o_tx_valid=0 on the next cycle.
REQ-007 FIFO SHALL store {wctrl, wdata} per entry using wrapping read/write pointers plus an occupancy count of width clog2(BUF_DEPTH)+1.
REQ-008 o_buf_empty SHALL be combinational and equal to (count==0).
REQ-009 Write SHALL occur when i_buf_wen=1 and either the FIFO is not full or a read happens in the same cycle; simultaneous read and write SHALL leave count unchanged.
REQ-010 A write to a full FIFO with no same-cycle read SHALL be dropped and SHALL set o_overflow.
REQ-011 i_buf_clear SHALL zero both pointers and count, and SHALL take precedence over any same-cycle write or read.
REQ-012 Output word select priority SHALL be gen_error > gen_hdr > gen_data > (gen_ifg | gen_idle); if no select is asserted, the output word SHALL be idle.
REQ-013 Error word: o_txc=all ones, every lane 0xFE.
REQ-014 Idle and IFG word: o_txc=all ones, every lane 0x07.
REQ-015 Header words:
- hdr_id 0: lanes {FB,55,55,55}, o_txc=0001.
- hdr_id 1: lanes {55,55,55,D5}, o_txc=0000.
REQ-016 Data word: o_txd/o_txc SHALL equal the FIFO head entry; the FIFO SHALL pop only when i_buf_ren=1 and the FIFO is non-empty.
REQ-017 gen_data with an empty FIFO SHALL emit the error word and SHALL set o_underflow.
REQ-018 Latency: o_txd, o_txc and o_tx_valid SHALL be registered, one cycle after the enabled select cycle.
REQ-019 FSM states:
- IDLE -> IN_FRAME on an emitted hdr_id 0 word.
- IN_FRAME -> IDLE when an emitted data word contains a lane with txc=1 and value 0xFD; this transition SHALL increment o_frame_cnt, which wraps 0xFFFF -> 0.
- IN_FRAME -> IDLE on an emitted error word, without incrementing o_frame_cnt.
REQ-020 gen_hdr with hdr_id 0 while in IN_FRAME SHALL emit the error word, set o_proto_err, and return the FSM to IDLE.
REQ-021 o_in_frame SHALL equal (state==IN_FRAME).
REQ-022 Sticky flags SHALL clear only on i_reset or on an enabled i_buf_clear; i_buf_clear SHALL leave o_frame_cnt unchanged.

Reset
REQ-023 On i_reset: pointers=0, count=0, o_buf_empty=1, o_txd=0x07070707, o_txc=1111, o_tx_valid=0, FSM=IDLE, o_frame_cnt=0, all sticky flags=0.
REQ-024 Reset asserted mid-frame SHALL discard FIFO contents; the first enabled cycle after reset with no select asserted SHALL output idle.

Verification
REQ-025 Minimal frame:
- Stimulus: hdr 0, hdr 1, 16 data words ending with term word {FD,07,07,07}, txc=1111.
- Response: o_txd sequence matches, o_frame_cnt=1, o_in_frame returns to 0.
REQ-026 Full FIFO:
- Stimulus: 9 writes with no reads (BUF_DEPTH=8).
- Response: o_overflow=1, count=8; then 8 reads return entries 0..7 in order.
REQ-027 Underflow: gen_data with the FIFO empty -> next o_txd=0xFEFEFEFE, o_txc=1111, o_underflow=1.
REQ-028 Simultaneous read/write on a full FIFO -> count stays 8, no overflow, FIFO order preserved.
REQ-029 Protocol error:
- Stimulus: hdr 0 issued twice without a term.
- Response: second output is the error word, o_proto_err=1, FSM in IDLE.
REQ-030 Clock-enable stall: hold i_clk_en=0 for 3 cycles mid-frame -> outputs frozen, o_tx_valid=0, no FIFO pops.
